// File: rtl/qar_mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, grant identifiers and the default bus-stall abort limit.
package qar_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GNT_I = 3'd1,
    ST_GNT_D = 3'd2,
    ST_RSP_I = 3'd3,
    ST_RSP_D = 3'd4
  } qar_state_e;

  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Stall counter is kept full-width so any TIMEOUT_CYCLES value fits.
  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/qar_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright; on a conflict the
// requester that did not win last time is chosen.
module qar_rr_arb2
  import qar_mem_pkg::*;
(
  input  logic req_instr,
  input  logic req_data,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pure combinational selection; the caller owns the last_grant register.
  always_comb begin
    gnt_valid = req_instr | req_data;
    gnt_id    = GNT_INSTR;
    if (req_instr && req_data) begin
      gnt_id = (last_grant == GNT_DATA) ? GNT_INSTR : GNT_DATA;
    end else if (req_data) begin
      gnt_id = GNT_DATA;
    end
  end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared memory bus.
// Exactly one transaction is outstanding at a time.
//
// Handshake: a requester raises *_valid with its address (and write data);
// the arbiter samples it only in IDLE, drives bus_valid with registered
// address/data until bus_ready is seen (or the stall limit expires), then
// pulses the requester's *_ready for exactly one cycle with *_rdata valid in
// that same cycle. A requester may drop valid after being granted; the
// transaction still completes and the ready pulse is still issued.
module qar_mem_arbiter
  import qar_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch requester
  input  logic                  imem_valid,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  // load/store requester
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  // shared bus
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_timeout
);

  localparam logic                   TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [STALL_CNT_W-1:0] TIMEOUT_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES);

  qar_state_e             state_q,      state_d;
  logic                   last_grant_q, last_grant_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic                   timeout_q,    timeout_d;
  logic                   bus_we_q,     bus_we_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_q,   bus_addr_d;
  logic [DATA_WIDTH-1:0]  bus_wdata_q,  bus_wdata_d;
  logic [DATA_WIDTH-1:0]  imem_rdata_q, imem_rdata_d;
  logic [DATA_WIDTH-1:0]  mem_rdata_q,  mem_rdata_d;

  logic arb_valid;
  logic arb_id;
  logic timeout_hit;

  qar_rr_arb2 u_rr_arb2 (
    .req_instr  (imem_valid),
    .req_data   (mem_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  // The limit is reached on the stall cycle that would bring the count up to
  // TIMEOUT_CYCLES; bus_ready in that same cycle takes priority below.
  assign timeout_hit = TIMEOUT_EN && (stall_cnt_q == (TIMEOUT_LIMIT - 1'b1));

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = stall_cnt_q;
    timeout_d    = 1'b0;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    imem_rdata_d = imem_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          last_grant_d = arb_id;
          stall_cnt_d  = '0;
          if (arb_id == GNT_INSTR) begin
            state_d     = ST_GNT_I;
            bus_addr_d  = imem_addr;
            bus_we_d    = 1'b0;
            bus_wdata_d = '0;
          end else begin
            state_d     = ST_GNT_D;
            bus_addr_d  = mem_addr;
            bus_we_d    = mem_we;
            bus_wdata_d = mem_wdata;
          end
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        if (bus_ready) begin
          if (state_q == ST_GNT_I) begin
            state_d      = ST_RSP_I;
            imem_rdata_d = bus_rdata;
          end else begin
            state_d = ST_RSP_D;
            // A store returns no data, so the load result register is kept.
            if (!bus_we_q) mem_rdata_d = bus_rdata;
          end
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          if (state_q == ST_GNT_I) begin
            state_d      = ST_RSP_I;
            imem_rdata_d = '0;
          end else begin
            state_d = ST_RSP_D;
            if (!bus_we_q) mem_rdata_d = '0;
          end
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end

      ST_RSP_I, ST_RSP_D: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_DATA;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      imem_rdata_q <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign bus_valid   = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_timeout = timeout_q;
  assign imem_ready  = (state_q == ST_RSP_I);
  assign mem_ready   = (state_q == ST_RSP_D);
  assign imem_rdata  = imem_rdata_q;
  assign mem_rdata   = mem_rdata_q;

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Bench for qar_mem_arbiter. A transaction-level model plans each grant
// (owner, bus window, response cycle, returned data) from the arbitration
// rules and the chosen bus wait count, then every cycle's outputs are
// compared against that plan.
module tb_qar_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic          imem_valid;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          bus_valid;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;
  logic          bus_timeout;

  qar_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_valid  (imem_valid),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .bus_valid   (bus_valid),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .bus_timeout (bus_timeout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int t        = 0;   // cycle index, advanced at each falling edge

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, t);
    end
  endtask

  // ---------------- requester / model state ----------------
  bit            pend_i, pend_d;   // valid currently held
  bit            out_i, out_d;     // granted and awaiting ready
  logic [AW-1:0] req_i_addr, req_d_addr;
  logic          req_d_we;
  logic [DW-1:0] req_d_wdata;

  bit            last_is_data;
  int            next_free;
  bit            act;
  bit            own_d;
  bit            to;
  int            s, e, r, w;
  logic [DW-1:0] rd_val;
  logic [AW-1:0] x_addr;
  logic          x_we;
  logic [DW-1:0] x_wdata;

  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [DW-1:0] exp_wdata, exp_irdata, exp_mrdata;

  // stimulus controls
  int            force_wait;
  bit            gen_en, drop_en, alt_en, rd_fixed_en;
  logic [DW-1:0] rd_fixed;
  int            alt_i, alt_d;

  // start-of-transaction scoreboard
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_q[$];
  logic          prev_bv;

  task automatic drive_inputs();
    imem_valid = pend_i;
    imem_addr  = req_i_addr;
    mem_valid  = pend_d;
    mem_we     = req_d_we;
    mem_addr   = req_d_addr;
    mem_wdata  = req_d_wdata;
  endtask

  task automatic model_init();
    pend_i = 0; pend_d = 0; out_i = 0; out_d = 0;
    req_i_addr = '0; req_d_addr = '0; req_d_we = 1'b0; req_d_wdata = '0;
    last_is_data = 1'b1;
    act = 1'b0;
    exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
    exp_irdata = '0; exp_mrdata = '0;
    prev_bv = 1'b0;
  endtask

  // One cycle: check outputs against the plan, then set next inputs.
  task automatic step();
    @(negedge clk);
    t++;
    if (act && t == r) begin
      if (!own_d) exp_irdata = to ? '0 : rd_val;
      else if (!x_we) exp_mrdata = to ? '0 : rd_val;
    end
    if (act && t == s) begin
      exp_addr  = x_addr;
      exp_we    = x_we;
      exp_wdata = x_wdata;
    end
    chk("bus_valid",   bus_valid,   act && t >= s && t <= e);
    chk("bus_addr",    bus_addr,    exp_addr);
    chk("bus_we",      bus_we,      exp_we);
    chk("bus_wdata",   bus_wdata,   exp_wdata);
    chk("imem_ready",  imem_ready,  act && t == r && !own_d);
    chk("mem_ready",   mem_ready,   act && t == r && own_d);
    chk("bus_timeout", bus_timeout, act && t == r && to);
    chk("imem_rdata",  imem_rdata,  exp_irdata);
    chk("mem_rdata",   mem_rdata,   exp_mrdata);
    if (bus_valid && !prev_bv) obs_q.push_back(bus_addr);
    prev_bv = bus_valid;

    // retire the transaction whose ready pulse is this cycle
    if (act && t == r) begin
      if (own_d) begin out_d = 0; pend_d = 0; end
      else begin out_i = 0; pend_i = 0; end
      act = 1'b0;
    end

    // new requests
    if (alt_en) begin
      if (!pend_i && !out_i && alt_i < 3) begin
        pend_i = 1; req_i_addr = 32'h1000 + AW'(alt_i); alt_i++;
      end
      if (!pend_d && !out_d && alt_d < 3) begin
        pend_d = 1; req_d_addr = 32'h2000 + AW'(alt_d); req_d_we = 1'b0;
        req_d_wdata = '0; alt_d++;
      end
    end else if (gen_en) begin
      if (!pend_i && !out_i && $urandom_range(0, 2) == 0) begin
        pend_i = 1; req_i_addr = $urandom();
      end
      if (!pend_d && !out_d && $urandom_range(0, 2) == 0) begin
        pend_d = 1; req_d_addr = $urandom(); req_d_we = 1'($urandom_range(0, 1));
        req_d_wdata = $urandom();
      end
    end
    // requester abandoning valid after being granted
    if (drop_en && act && t >= s && $urandom_range(0, 3) == 0) begin
      if (own_d) pend_d = 0;
      else pend_i = 0;
    end
    drive_inputs();

    // plan a grant when the arbiter samples requests at the end of this cycle
    if (!act && t >= next_free && (pend_i || pend_d)) begin
      own_d        = (pend_i && pend_d) ? !last_is_data : pend_d;
      last_is_data = own_d;
      act          = 1'b1;
      s            = t + 1;
      w            = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 5));
      if (own_d && req_d_we && w >= TO) w = int'($urandom_range(0, TO - 1));
      to           = (w >= TO);
      e            = to ? s + TO - 1 : s + w;
      r            = e + 1;
      next_free    = r + 1;
      if (own_d) begin
        out_d = 1; x_addr = req_d_addr; x_we = req_d_we; x_wdata = req_d_we ? req_d_wdata : req_d_wdata;
      end else begin
        out_i = 1; x_addr = req_i_addr; x_we = 1'b0; x_wdata = '0;
      end
    end

    // bus responder
    if (act && !to && t == s + w) begin
      bus_ready = 1'b1;
      bus_rdata = rd_fixed_en ? rd_fixed : DW'($urandom());
      rd_val    = bus_rdata;
    end else if (act && t >= s && t <= e) begin
      bus_ready = 1'b0;
      bus_rdata = $urandom();
    end else begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom();
    end
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus_valid",   bus_valid,   1'b0);
    chk("rst_bus_we",      bus_we,      1'b0);
    chk("rst_bus_addr",    bus_addr,    '0);
    chk("rst_bus_wdata",   bus_wdata,   '0);
    chk("rst_imem_ready",  imem_ready,  1'b0);
    chk("rst_mem_ready",   mem_ready,   1'b0);
    chk("rst_bus_timeout", bus_timeout, 1'b0);
    chk("rst_imem_rdata",  imem_rdata,  '0);
    chk("rst_mem_rdata",   mem_rdata,   '0);
    model_init();
    drive_inputs();
    bus_ready = 1'b0;
    bus_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      t++;
    end
    rst_n     = 1'b1;
    next_free = t;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b1;
    force_wait = -1; gen_en = 0; drop_en = 0; alt_en = 0;
    rd_fixed_en = 0; rd_fixed = '0; alt_i = 0; alt_d = 0;
    model_init();
    drive_inputs();
    bus_ready = 1'b0;
    bus_rdata = '0;
    #1;
    apply_reset();

    // lone fetch, zero-wait bus
    force_wait = 0; rd_fixed_en = 1; rd_fixed = 32'h0000_0013;
    pend_i = 1; req_i_addr = 32'h10;
    repeat (6) step();

    // simultaneous fetch and store straight after reset
    apply_reset();
    pend_i = 1; req_i_addr = 32'h20;
    pend_d = 1; req_d_addr = 32'h100; req_d_we = 1'b1; req_d_wdata = 32'hCAFE_F00D;
    rd_fixed = 32'h1234_5678;
    repeat (10) step();

    // six back-to-back conflicts must alternate I,D,I,D,I,D
    apply_reset();
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h1000 + AW'(k));
      exp_q.push_back(32'h2000 + AW'(k));
    end
    force_wait = -1; rd_fixed_en = 0; alt_en = 1; alt_i = 0; alt_d = 0;
    for (int c = 0; c < 80 && obs_q.size() < 6; c++) step();
    repeat (8) step();
    alt_en = 0;
    chk("alt_count", 64'(obs_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("alt_order", obs_q[k], exp_q[k]);

    // a load that returns data, then one stalled into the timeout
    force_wait = 0; rd_fixed_en = 1; rd_fixed = 32'hA5A5_0001;
    pend_d = 1; req_d_addr = 32'h300; req_d_we = 1'b0;
    repeat (6) step();
    force_wait = 20;
    pend_d = 1; req_d_addr = 32'h304; req_d_we = 1'b0;
    repeat (10) step();

    // bus_ready on the very cycle the limit is reached
    force_wait = TO - 1; rd_fixed = 32'h0BAD_BEEF;
    pend_d = 1; req_d_addr = 32'h308; req_d_we = 1'b0;
    repeat (10) step();

    // reset while the load/store grant is on the bus
    force_wait = 20;
    pend_d = 1; req_d_addr = 32'h30C; req_d_we = 1'b0;
    for (int c = 0; c < 10 && !(act && t >= s + 1); c++) step();
    chk("gnt_d_before_rst", bus_valid, 1'b1);
    apply_reset();
    repeat (8) step();

    // randomized traffic with wait states, timeouts and dropped valids
    force_wait = -1; rd_fixed_en = 0; gen_en = 1; drop_en = 1;
    repeat (1500) step();
    gen_en = 0; drop_en = 0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
